keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks each column stays driven while idle-scanning; legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 10000: consecutive stable synchronized clocks needed to accept a press or a release; legal range >= 2.
REQ-003 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-004 Port nst, input, 1: reset, synchronous and active-high.
REQ-005 Port row, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port col, output, 4: keypad column drive, one-cold (exactly one bit low).
REQ-007 Port key_value, output, 4: code of the last accepted key, held until the next accepted key.
REQ-008 Port key_valid, output, 1: one-clock pulse in the cycle key_value updates.
REQ-009 Port key_down, output, 1: high from acceptance of a press until acceptance of its release.

Function
REQ-010 row shall pass through a 2-flop synchronizer; all decisions use the synchronized value rs, so the input-to-decision latency is 2 clocks.
REQ-011 The FSM shall have exactly the states SCAN, PRESS_DB, HOLD and RELEASE_DB.
REQ-012 SCAN: col index c (0..3) drives col = ~(1<<c); a divider counts 0..SCAN_DIV-1; at terminal count with rs==4'hF, c advances and wraps from 3 to 0.
REQ-013 SCAN -> PRESS_DB when rs!=4'hF at divider terminal count; capture rs as the candidate and clear the debounce counter.
REQ-014 In PRESS_DB, HOLD and RELEASE_DB, col shall stay frozen on c.
REQ-015 PRESS_DB: rs==candidate increments the counter; rs==4'hF -> SCAN with c unchanged and the divider cleared; any other nonzero pattern reloads the candidate and clears the counter.
REQ-016 PRESS_DB -> HOLD when the counter reaches DB_CYCLES-1 with rs==candidate; in that clock latch key_value, pulse key_valid and set key_down.
REQ-017 key code = r*4 + c, where r is the lowest row index with a low candidate bit (multi-row press: lowest row wins).
REQ-018 HOLD -> RELEASE_DB when rs==4'hF; otherwise stay (no auto-repeat).
REQ-019 RELEASE_DB: count clocks with rs==4'hF; any rs!=4'hF -> HOLD with the counter cleared; at DB_CYCLES-1 clear key_down, advance c with wrap, clear the divider and enter SCAN.
REQ-020 key_valid shall never assert on two consecutive clocks; exactly one pulse per accepted press.
REQ-021 Counter widths shall be $clog2 of their parameter; no counter shall pass its terminal value.

Reset
REQ-022 While nst=1: state=SCAN, c=0, col=4'b1110, key_value=4'h0, key_valid=0, key_down=0, counters=0, synchronizer flops=4'hF.
REQ-023 nst asserted mid-debounce or in HOLD shall abort the FSM without a key_valid pulse; after release the block resumes scanning from column 0.

Structure
REQ-024 The FSM state encoding and the key-code width constant (4) shall live in the shared maze package used by the command stage.
REQ-025 The debounce counter shall be one sub-module, key_debounce_cnt (clear, enable, terminal flag), instantiated once and shared by PRESS_DB and RELEASE_DB.
REQ-026 key_value/key_valid shall connect directly to the command stage's key_value input; no further buffering is required.

Verification (SCAN_DIV=4, DB_CYCLES=8)
REQ-027 Reset then idle rows=F for 40 clocks -> col cycles E,D,B,7,E every 4 clocks; key_valid never asserts.
REQ-028 Press r=2,c=1 (row bit2 low while col=D), held 30 clocks -> single key_valid pulse with key_value=9, 2+8 clocks after first sampled; key_down=1.
REQ-029 Release after REQ-028 -> key_down falls 2+8 clocks after row returns to F; col then advances to B.
REQ-030 Bounce: the row toggles every 3 clocks for 20 clocks, then is stable -> no pulse during toggling; exactly one pulse after 8 stable clocks.
REQ-031 Rows 1 and 3 low on c=3 -> key_value=7 (lowest row wins).
REQ-032 nst pulsed at counter=5 in PRESS_DB -> no key_valid pulse; col=E the clock after reset is deasserted.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared keypad definitions: scan FSM states, key-code width and the
// row/column to key-code mapping used by the scanner and the command stage.
package keypad_scan_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HOLD,
    RELEASE_DB
  } scan_state_t;

  // Lowest active (low) row wins when several rows are pressed together
  function automatic logic [KEY_W-1:0] key_code(input logic [3:0] rows,
                                                input logic [1:0] col_idx);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = i[1:0];
    end
    return {r, col_idx};
  endfunction

endpackage

// File: rtl/key_debounce_cnt.sv
// Saturating debounce counter shared by the press and release debounce states;
// term flags that the input has been stable for LIMIT consecutive clocks.
module key_debounce_cnt #(
  parameter int LIMIT = 10000
) (
  input  logic clk,
  input  logic nst,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam int W = $clog2(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (nst || clear) begin
      count <= '0;
    end else if (enable && !term) begin
      count <= count + W'(1);
    end
  end

  assign term = (count == W'(LIMIT - 1));

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, debounces presses
// and releases, and reports each accepted key once with a single-clock pulse.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DB_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             nst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_value,
  output logic             key_valid,
  output logic             key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  scan_state_t state, next_state;

  logic [3:0]       rs_meta, rs, cand;
  logic [1:0]       c;
  logic [DIV_W-1:0] div;
  logic             div_term, rows_idle, cand_match;
  logic             db_clear, db_en, db_term;
  logic             accept, release_done, cand_load, col_adv;

  assign div_term   = (div == DIV_W'(SCAN_DIV - 1));
  assign rows_idle  = (rs == 4'hF);
  assign cand_match = (rs == cand);

  key_debounce_cnt #(
    .LIMIT (DB_CYCLES)
  ) u_db_cnt (
    .clk    (clk),
    .nst    (nst),
    .clear  (db_clear),
    .enable (db_en),
    .term   (db_term)
  );

  always_ff @(posedge clk) begin
    if (nst) state <= SCAN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SCAN: begin
        if (div_term && !rows_idle) next_state = PRESS_DB;
      end
      PRESS_DB: begin
        if (rows_idle)                  next_state = SCAN;
        else if (cand_match && db_term) next_state = HOLD;
      end
      HOLD: begin
        if (rows_idle) next_state = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (!rows_idle)   next_state = HOLD;
        else if (db_term) next_state = SCAN;
      end
      default: next_state = SCAN;
    endcase
  end

  // Column drive and datapath strobes; col stays frozen outside SCAN
  always_comb begin
    col          = ~(4'b0001 << c);
    db_clear     = 1'b0;
    db_en        = 1'b0;
    accept       = 1'b0;
    release_done = 1'b0;
    cand_load    = 1'b0;
    col_adv      = 1'b0;
    case (state)
      SCAN: begin
        db_clear  = 1'b1;
        cand_load = div_term && !rows_idle;
        col_adv   = div_term && rows_idle;
      end
      PRESS_DB: begin
        if (rows_idle) begin
          db_clear = 1'b1;
        end else if (cand_match) begin
          if (db_term) accept = 1'b1;
          else         db_en  = 1'b1;
        end else begin
          cand_load = 1'b1;
          db_clear  = 1'b1;
        end
      end
      HOLD: begin
        db_clear = 1'b1;
      end
      RELEASE_DB: begin
        if (!rows_idle) begin
          db_clear = 1'b1;
        end else if (db_term) begin
          release_done = 1'b1;
          col_adv      = 1'b1;
          db_clear     = 1'b1;
        end else begin
          db_en = 1'b1;
        end
      end
      default: db_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nst) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (nst) begin
      c         <= 2'd0;
      div       <= '0;
      cand      <= 4'hF;
      key_value <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept;
      div       <= (state == SCAN && !div_term) ? div + DIV_W'(1) : '0;
      if (col_adv)   c    <= c + 2'd1;
      if (cand_load) cand <= rs;
      if (accept) begin
        key_value <= key_code(cand, c);
        key_down  <= 1'b1;
      end else if (release_done) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule
